// File: rtl/ledr_seq_pkg.sv
// Shared types and CSR map for the LED pattern sequencer.
package ledr_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_SHIFT  = 2'd2,
    MODE_BOUNCE = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

endpackage

// File: rtl/ledr_seq_prescaler.sv
// Loadable step-period down-counter; saturates at zero and flags it.
module ledr_seq_prescaler #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 r_cnt <= '0;
    else if (i_load)              r_cnt <= i_load_val;
    else if (i_dec && !o_zero)    r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ledr_pattern_sequencer.sv
// CSR-programmed LED pattern engine writing one-cycle strobes to a PIO.
// Define LEDR_PATTERN_SEQUENCER_BOUNCE_EN for bounce mode and STATUS dir.
module ledr_pattern_sequencer
  import ledr_seq_pkg::*;
#(
  parameter int LED_W      = 18,
  parameter int PRESCALE_W = 26
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata
);

  logic w_csr_wr, w_wr_ctrl, w_wr_pat, w_wr_per;
  assign w_csr_wr  = s_chipselect & ~s_write_n;
  assign w_wr_ctrl = w_csr_wr && (s_address == ADDR_CTRL);
  assign w_wr_pat  = w_csr_wr && (s_address == ADDR_PATTERN);
  assign w_wr_per  = w_csr_wr && (s_address == ADDR_PERIOD);

  logic                  r_en;
  mode_e                 r_mode;
  logic [LED_W-1:0]      r_pattern;
  logic [PRESCALE_W-1:0] r_period;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en      <= 1'b0;
      r_mode    <= MODE_STATIC;
      r_pattern <= '0;
      r_period  <= PRESCALE_W'(1);
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= s_writedata[0];
        r_mode <= mode_e'(s_writedata[2:1]);
      end
      if (w_wr_pat) r_pattern <= s_writedata[LED_W-1:0];
      if (w_wr_per) r_period  <= s_writedata[PRESCALE_W-1:0];
    end
  end

  state_e           r_state, w_state_nxt;
  logic [LED_W-1:0] r_work, w_work_nxt;
  logic [15:0]      r_step, w_step_nxt;
  logic             w_ps_load, w_ps_dec, w_ps_zero, w_dir_clr, w_dir_adv;

  // PERIOD of 0 behaves as 1, so both reload a count of 0
  logic [PRESCALE_W-1:0] w_reload;
  assign w_reload = (r_period == '0) ? '0 : r_period - PRESCALE_W'(1);

  ledr_seq_prescaler #(.W(PRESCALE_W)) u_prescaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_ps_load),
    .i_load_val (w_reload),
    .i_dec      (w_ps_dec),
    .o_zero     (w_ps_zero)
  );

  logic [LED_W-1:0] w_rot, w_bnc_work, w_adv_work;
  logic             w_dir;
  logic             w_unused;
  assign w_rot = {r_work[LED_W-2:0], r_work[LED_W-1]};

`ifdef LEDR_PATTERN_SEQUENCER_BOUNCE_EN
  logic r_dir, w_bnc_dir;

  // dir flips once the shifted value reaches the edge it was heading for
  always_comb begin
    w_bnc_work = r_work << 1;
    w_bnc_dir  = w_bnc_work[LED_W-1];
    if (r_dir) begin
      w_bnc_work = r_work >> 1;
      w_bnc_dir  = ~w_bnc_work[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               r_dir <= 1'b0;
    else if (w_dir_clr)                         r_dir <= 1'b0;
    else if (w_dir_adv && r_mode == MODE_BOUNCE) r_dir <= w_bnc_dir;
  end

  assign w_dir    = r_dir;
  assign w_unused = ^s_writedata;
`else
  assign w_bnc_work = w_rot;
  assign w_dir      = 1'b0;
  assign w_unused   = ^{s_writedata, w_dir_clr, w_dir_adv};
`endif

  always_comb begin
    w_adv_work = r_work;
    case (r_mode)
      MODE_BLINK:  w_adv_work = (r_work == '0) ? r_pattern : '0;
      MODE_SHIFT:  w_adv_work = w_rot;
      MODE_BOUNCE: w_adv_work = w_bnc_work;
      default:     w_adv_work = r_work;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_step_nxt  = r_step;
    w_ps_load   = 1'b0;
    w_ps_dec    = 1'b0;
    w_dir_clr   = 1'b0;
    w_dir_adv   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_en) begin
          w_work_nxt  = r_pattern;
          w_step_nxt  = '0;
          w_dir_clr   = 1'b1;
          w_state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        w_step_nxt  = r_step + 16'd1;
        w_ps_load   = 1'b1;
        w_state_nxt = (r_mode == MODE_STATIC) ? ST_HOLD : ST_WAIT;
      end
      ST_WAIT: begin
        if (w_ps_zero) begin
          w_work_nxt  = w_adv_work;
          w_dir_adv   = 1'b1;
          w_state_nxt = ST_WRITE;
        end else begin
          w_ps_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_wr_ctrl && s_writedata[0] && (s_writedata[2:1] != r_mode))
          w_state_nxt = ST_WRITE;
      end
      ST_CLEAR: begin
        w_work_nxt  = '0;
        w_step_nxt  = '0;
        w_dir_clr   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // disable beats a PATTERN write, which beats prescaler expiry
    if (r_state != ST_IDLE && r_state != ST_CLEAR) begin
      if (!r_en) begin
        w_state_nxt = ST_CLEAR;
        w_dir_adv   = 1'b0;
      end else if (w_wr_pat) begin
        w_work_nxt  = s_writedata[LED_W-1:0];
        w_dir_clr   = 1'b1;
        w_dir_adv   = 1'b0;
        w_state_nxt = ST_WRITE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_work  <= '0;
      r_step  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_step  <= w_step_nxt;
    end
  end

  assign m_address    = 2'b00;
  assign m_chipselect = (r_state == ST_WRITE) || (r_state == ST_CLEAR);
  assign m_write_n    = ~m_chipselect;
  assign m_writedata  = (r_state == ST_WRITE) ? 32'(r_work) : 32'h0;

  always_comb begin
    s_readdata = '0;
    case (s_address)
      ADDR_CTRL:    s_readdata = {29'd0, r_mode, r_en};
      ADDR_PATTERN: s_readdata = 32'(r_pattern);
      ADDR_PERIOD:  s_readdata = 32'(r_period);
      default:      s_readdata = {r_step, 14'd0, w_dir, (r_state != ST_IDLE)};
    endcase
  end

endmodule

// File: tb/tb_ledr_pattern_sequencer.sv
// Randomized bench: predicts the PIO write stream (time, data, STATUS) per scenario.
`timescale 1ns/1ps
module tb_ledr_pattern_sequencer;
  localparam int LED_W      = 18;
  localparam int PRESCALE_W = 26;
  localparam logic [31:0] MASK = (32'd1 << LED_W) - 32'd1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  s_address = 2'd3;
  logic        s_chipselect = 1'b0;
  logic        s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata, m_writedata;
  logic [1:0]  m_address;
  logic        m_chipselect, m_write_n;

  ledr_pattern_sequencer #(.LED_W(LED_W), .PRESCALE_W(PRESCALE_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_address    (s_address),
    .s_chipselect (s_chipselect),
    .s_write_n    (s_write_n),
    .s_writedata  (s_writedata),
    .s_readdata   (s_readdata),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  typedef struct {
    int          c;
    logic [31:0] d;
    logic [31:0] st;
    bit          stv;
  } wr_t;

  wr_t mon_q[$];
  wr_t exp_q[$];

  // STATUS is only trusted when the bench is not using the CSR port
  always @(negedge clk) begin : mon
    wr_t e;
    if (reset_n && m_chipselect && !m_write_n) begin
      e.c   = cyc;
      e.d   = m_writedata;
      e.st  = s_readdata;
      e.stv = (s_address == 2'd3) && !s_chipselect;
      mon_q.push_back(e);
    end
  end

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d, output int c);
    c = cyc;
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(posedge clk); #1;
    s_chipselect = 1'b0; s_write_n = 1'b1; s_address = 2'd3;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    s_address = a; #1;
    d = s_readdata;
    s_address = 2'd3;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin @(posedge clk); #1; end
  endtask

  // Writes of one segment: one every s_len clocks from t0, values by the mode's rule
  task automatic seg(input int t0, input int lim, input int mode, input int s_len,
                     input logic [31:0] v0, inout int k);
    logic [31:0] v;
    bit dir;
    wr_t e;
    v = v0; dir = 1'b0;
    for (int t = t0; t <= lim; t += s_len) begin
      e.c = t; e.d = v; e.st = {k[15:0], 14'd0, dir, 1'b1}; e.stv = 1'b1;
      exp_q.push_back(e);
      k++;
      if (mode == 0) break;
      if (mode == 1) v = (v == 0) ? v0 : 32'd0;
      else if (mode == 2) v = ((v << 1) | (v >> (LED_W-1))) & MASK;
      else begin
`ifdef LEDR_PATTERN_SEQUENCER_BOUNCE_EN
        if (!dir) begin
          v = (v << 1) & MASK;
          if (v[LED_W-1]) dir = 1'b1;
        end else begin
          v = v >> 1;
          if (v[0]) dir = 1'b0;
        end
`else
        v = ((v << 1) | (v >> (LED_W-1))) & MASK;
`endif
      end
    end
  endtask

  task automatic scenario(input string nm, input int mode, input logic [31:0] pat,
                          input int per, input int nw, input bit pw_en, input int pw_sel,
                          input logic [31:0] pat2);
    int c0, cd, x, s_len, k, dmy;
    logic [31:0] rd;
    wr_t e;
    csr_wr(2'd1, pat, dmy);
    csr_wr(2'd2, 32'(per), dmy);
    mon_q.delete(); exp_q.delete();
    csr_wr(2'd0, 32'((mode << 1) | 1), c0);
    s_len = ((per < 1) ? 1 : per) + 1;
    cd = c0 + 2 + nw * s_len + int'($urandom_range(0, s_len - 1));
    x  = c0 + 2 + ((pw_sel < 0) ? int'($urandom_range(0, cd - c0 - 3)) : pw_sel);
    if (pw_en) begin
      wait_to(x);
      csr_wr(2'd1, pat2, dmy);
    end
    wait_to(cd);
    csr_wr(2'd0, 32'(mode << 1), dmy);
    repeat (4) begin @(posedge clk); #1; end
    csr_rd(2'd3, rd);
    chk({nm, " status_off"}, rd, 32'd0);
    k = 0;
    seg(c0 + 2, pw_en ? x : cd + 1, mode, s_len, pat & MASK, k);
    if (pw_en) seg(x + 1, cd + 1, mode, s_len, pat2 & MASK, k);
    e.c = cd + 2; e.d = 32'd0; e.st = 32'd0; e.stv = 1'b0;
    exp_q.push_back(e);
    chk({nm, " nwr"}, mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      chk($sformatf("%s[%0d] cyc", nm, i), mon_q[i].c, exp_q[i].c);
      chk($sformatf("%s[%0d] data", nm, i), mon_q[i].d, exp_q[i].d);
      if (mon_q[i].stv && exp_q[i].stv)
        chk($sformatf("%s[%0d] status", nm, i), mon_q[i].st, exp_q[i].st);
    end
  endtask

  initial begin
    logic [31:0] rd;
    int dmy;
    bit seen;
    repeat (3) @(posedge clk);
    #1;
    chk("rst cs", 32'(m_chipselect), 32'd0);
    chk("rst wn", 32'(m_write_n), 32'd1);
    chk("rst wd", m_writedata, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    csr_rd(2'd0, rd); chk("rst ctrl", rd, 32'd0);
    csr_rd(2'd1, rd); chk("rst pattern", rd, 32'd0);
    csr_rd(2'd2, rd); chk("rst period", rd, 32'd1);
    csr_rd(2'd3, rd); chk("rst status", rd, 32'd0);
    chk("maddr", 32'(m_address), 32'd0);

    scenario("static",  0, 32'h00055, 4, 3,  1'b0, 0, 32'h0);
    scenario("shift",   2, 32'h20000, 3, 4,  1'b0, 0, 32'h0);
    scenario("bounce",  3, 32'h00001, 1, 20, 1'b0, 0, 32'h0);
    scenario("blink",   1, 32'h3FFFF, 2, 5,  1'b0, 0, 32'h0);
    scenario("collide", 2, 32'h00003, 3, 5,  1'b1, 3, 32'h00100);
    scenario("per0",    2, 32'h00005, 0, 6,  1'b0, 0, 32'h0);
    scenario("hold_pw", 0, 32'h00012, 2, 2,  1'b1, 1, 32'h00034);
    csr_rd(2'd2, rd); chk("period rb", rd, 32'd2);

    for (int r = 0; r < 16; r++)
      scenario($sformatf("rnd%0d", r), int'($urandom_range(0, 3)), $urandom & MASK,
               int'($urandom_range(0, 5)), int'($urandom_range(2, 6)),
               1'($urandom_range(0, 1)), -1, $urandom & MASK);

    // asynchronous reset in the middle of a strobe
    csr_wr(2'd1, 32'h000FF, dmy);
    csr_wr(2'd2, 32'd5, dmy);
    csr_wr(2'd0, 32'h5, dmy);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = m_chipselect;
    end
    chk("rst_mid strobe_seen", 32'(seen), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid cs", 32'(m_chipselect), 32'd0);
    chk("rst_mid wn", 32'(m_write_n), 32'd1);
    chk("rst_mid wd", m_writedata, 32'd0);
    csr_rd(2'd0, rd); chk("rst_mid ctrl", rd, 32'd0);
    csr_rd(2'd2, rd); chk("rst_mid period", rd, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("post_rst cs", 32'(m_chipselect), 32'd0);
    csr_rd(2'd3, rd); chk("post_rst status", rd, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
